// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch: BOOT/REQ/HOLD, one word per (memory latency + 2) cycles, no prefetch.
// Decode backpressure holds instr/instr_pc/instr_valid in HOLD; define IFETCH_WATCHDOG_EN for a sticky fetch timeout.
module ifetch_unit (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic [63:0] currentpc,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [63:0] addr_nxt;
  logic [63:0] redir_tgt;
  logic [63:0] boot_pc;
  logic        discard, discard_nxt;
  logic        ivld_nxt;
  logic        capture;
  logic        ack;

  assign redir_tgt = redirect_pc & ~64'd3;
  assign boot_pc   = startpc & ~64'd3;
  assign ack       = imem_ack & (state == REQ);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    addr_nxt    = imem_addr;
    discard_nxt = discard;
    ivld_nxt    = instr_valid;
    capture     = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = REQ;
        pc_nxt    = boot_pc;
        addr_nxt  = boot_pc;
      end
      REQ: begin
        // imem_addr only moves once the outstanding request has been acked
        if (ack) begin
          discard_nxt = 1'b0;
          if (discard || redirect_valid) begin
            if (redirect_valid) pc_nxt = redir_tgt;
            addr_nxt = pc_nxt;
          end else begin
            capture   = 1'b1;
            ivld_nxt  = 1'b1;
            pc_nxt    = pc + 64'd4;
            state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          discard_nxt = 1'b1;
          pc_nxt      = redir_tgt;
        end
      end
      HOLD: begin
        if (redirect_valid || instr_ready) begin
          ivld_nxt  = 1'b0;
          state_nxt = REQ;
          if (redirect_valid) pc_nxt = redir_tgt;
          addr_nxt = pc_nxt;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= BOOT;
      pc          <= '0;
      imem_addr   <= '0;
      discard     <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      imem_addr   <= addr_nxt;
      discard     <= discard_nxt;
      instr_valid <= ivld_nxt;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  assign imem_req  = (state == REQ);
  assign currentpc = pc;

`ifdef IFETCH_WATCHDOG_EN
  logic [7:0] wd_cnt;
  logic       wd_flag;

  // Saturating count of consecutive un-acked REQ cycles; the flag stays set until reset.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      wd_cnt  <= '0;
      wd_flag <= 1'b0;
    end else if (state == REQ) begin
      if (imem_ack) begin
        wd_cnt <= '0;
      end else if (wd_cnt != 8'hFF) begin
        wd_cnt <= wd_cnt + 8'd1;
        if (wd_cnt == 8'hFE) wd_flag <= 1'b1;
      end
    end
  end

  assign fetch_timeout = wd_flag;
`else
  assign fetch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a latency-programmable memory model and a decode handshake log.
module tb_ifetch_unit;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [63:0] startpc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic [63:0] currentpc;
  logic        fetch_timeout;

  logic        mem_ack;
  logic        stray_ack;
  bit          mem_en;
  int          mem_lat;
  int          mem_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] hs_pc[$];
  logic [31:0] hs_ins[$];
  int          hs_cyc[$];

`ifdef IFETCH_WATCHDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif

  always #5 CLK = ~CLK;

  assign imem_ack = mem_ack | stray_ack;

  ifetch_unit dut (
    .CLK            (CLK),
    .resetl         (resetl),
    .startpc        (startpc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .currentpc      (currentpc),
    .fetch_timeout  (fetch_timeout)
  );

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'hA5C3_3C5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory acks once the request has been up for more than mem_lat negedges.
  always @(negedge CLK) begin
    if (!mem_en) begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      mem_cnt = imem_req ? 1 : 0;
    end else if (imem_req) begin
      mem_cnt++;
      if (mem_cnt > mem_lat) begin
        mem_ack    = 1'b1;
        imem_rdata = word_of(imem_addr);
      end
    end else begin
      mem_cnt = 0;
    end
  end

  always @(negedge CLK) begin
    if (resetl && instr_valid && instr_ready) begin
      hs_pc.push_back(instr_pc);
      hs_ins.push_back(instr);
      hs_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [63:0] hs_pc_at(input int i);
    return (hs_pc.size() > i) ? hs_pc[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [31:0] hs_ins_at(input int i);
    return (hs_ins.size() > i) ? hs_ins[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic int hs_cyc_at(input int i);
    return (hs_cyc.size() > i) ? hs_cyc[i] : -1000;
  endfunction

  task automatic do_reset(input logic [63:0] spc, input int lat, input logic ready);
    @(posedge CLK);
    #1;
    resetl         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = ready;
    startpc        = spc;
    mem_lat        = lat;
    mem_en         = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    hs_pc.delete();
    hs_ins.delete();
    hs_cyc.delete();
    resetl = 1'b1;
  endtask

  task automatic wait_hs(input int n, input string tag);
    int k = 0;
    while (hs_pc.size() < n && k < 300) begin
      step();
      k++;
    end
    if (hs_pc.size() < n) chk({tag, "_hs_timeout"}, 64'(hs_pc.size()), 64'(n));
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!imem_req && k < 50) begin
      step();
      k++;
    end
    chk({tag, "_req_seen"}, 64'(imem_req), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!instr_valid && k < 50) begin
      step();
      k++;
    end
    chk({tag, "_valid_seen"}, 64'(instr_valid), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    resetl         = 1'b1;
    startpc        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    imem_rdata     = '0;
    mem_ack        = 1'b0;
    stray_ack      = 1'b0;
    mem_en         = 1'b0;
    mem_lat        = 1;
    mem_cnt        = 0;

    // Asynchronous reset before any clock edge
    #3 resetl = 1'b0;
    #1;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_currentpc", currentpc, 64'd0);
    chk("rst_timeout", 64'(fetch_timeout), 64'd0);

    // Streaming with 1-cycle memory and ready decode
    do_reset(64'h0, 1, 1'b1);
    wait_valid("stream");
    chk("stream_first_pc", instr_pc, 64'h0);
    chk("stream_currentpc", currentpc, 64'h4);
    chk("stream_hold_req", 64'(imem_req), 64'd0);
    wait_hs(3, "stream");
    chk("stream_pc0", hs_pc_at(0), 64'h0);
    chk("stream_pc1", hs_pc_at(1), 64'h4);
    chk("stream_pc2", hs_pc_at(2), 64'h8);
    chk("stream_ins2", 64'(hs_ins_at(2)), 64'(word_of(64'h8)));
    chk("stream_period01", 64'(hs_cyc_at(1) - hs_cyc_at(0)), 64'd3);
    chk("stream_period12", 64'(hs_cyc_at(2) - hs_cyc_at(1)), 64'd3);

    // Decode stall: held word must not move, memory idle in HOLD
    do_reset(64'h40, 4, 1'b0);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_pc_%0d", i), instr_pc, 64'h40);
      chk($sformatf("stall_ins_%0d", i), 64'(instr), 64'(word_of(64'h40)));
      chk($sformatf("stall_req_%0d", i), 64'(imem_req), 64'd0);
      step();
    end
    @(posedge CLK);
    #1 instr_ready = 1'b1;
    wait_hs(1, "stall");
    chk("stall_delivered_pc", hs_pc_at(0), 64'h40);
    chk("stall_count", 64'(hs_pc.size()), 64'd1);

    // Redirect while the request to 0x8 is outstanding
    do_reset(64'h8, 4, 1'b1);
    wait_req("redir");
    chk("redir_first_addr", imem_addr, 64'h8);
    @(posedge CLK);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    @(posedge CLK);
    #1;
    redirect_valid = 1'b0;
    chk("redir_addr_held", imem_addr, 64'h8);
    chk("redir_req_held", 64'(imem_req), 64'd1);
    chk("redir_currentpc", currentpc, 64'h100);
    begin
      int k = 0;
      while (imem_addr != 64'h100 && k < 50) begin
        step();
        k++;
      end
    end
    chk("redir_new_addr", imem_addr, 64'h100);
    chk("redir_no_deliver", 64'(hs_pc.size()), 64'd0);
    wait_hs(1, "redir");
    chk("redir_pc", hs_pc_at(0), 64'h100);
    chk("redir_ins", 64'(hs_ins_at(0)), 64'(word_of(64'h100)));

    // Redirect in HOLD coinciding with the handshake
    do_reset(64'h20, 1, 1'b0);
    wait_valid("hold_redir");
    @(posedge CLK);
    #1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    @(posedge CLK);
    #1;
    redirect_valid = 1'b0;
    chk("hold_redir_currentpc", currentpc, 64'h200);
    chk("hold_redir_addr", imem_addr, 64'h200);
    chk("hold_redir_valid", 64'(instr_valid), 64'd0);
    wait_hs(2, "hold_redir");
    chk("hold_redir_pc0", hs_pc_at(0), 64'h20);
    chk("hold_redir_pc1", hs_pc_at(1), 64'h200);
    chk("hold_redir_count", 64'(hs_pc.size()), 64'd2);

    // PC wraps past the top of the address space; startpc low bits are masked
    do_reset(64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1);
    wait_valid("wrap");
    chk("wrap_instr_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_currentpc", currentpc, 64'h0);
    wait_hs(2, "wrap");
    chk("wrap_next_pc", hs_pc_at(1), 64'h0);

    // Reset in the middle of a request, with a stray ack around it
    do_reset(64'h80, 6, 1'b1);
    wait_req("midrst");
    step();
    @(posedge CLK);
    #1;
    resetl    = 1'b0;
    stray_ack = 1'b1;
    #1;
    chk("midrst_req", 64'(imem_req), 64'd0);
    chk("midrst_addr", imem_addr, 64'd0);
    chk("midrst_currentpc", currentpc, 64'd0);
    startpc = 64'h60;
    repeat (2) @(posedge CLK);
    #1;
    chk("midrst_stray_valid", 64'(instr_valid), 64'd0);
    hs_pc.delete();
    hs_ins.delete();
    hs_cyc.delete();
    resetl = 1'b1;
    @(posedge CLK);
    #1;
    stray_ack = 1'b0;
    chk("midrst_boot_valid", 64'(instr_valid), 64'd0);
    chk("midrst_boot_req", 64'(imem_req), 64'd1);
    chk("midrst_boot_addr", imem_addr, 64'h60);
    wait_hs(1, "midrst");
    chk("midrst_pc", hs_pc_at(0), 64'h60);
    chk("midrst_ins", 64'(hs_ins_at(0)), 64'(word_of(64'h60)));

    // Memory that never answers
    do_reset(64'h300, 1, 1'b1);
    mem_en = 1'b0;
    wait_req("wd");
    repeat (254) step();
    chk("wd_before_255", 64'(fetch_timeout), 64'd0);
    step();
    chk("wd_at_255", 64'(fetch_timeout), 64'(WD));
    repeat (20) step();
    chk("wd_sticky", 64'(fetch_timeout), 64'(WD));
    chk("wd_still_req", 64'(imem_req), 64'd1);
    mem_en = 1'b1;
    wait_hs(1, "wd");
    chk("wd_late_pc", hs_pc_at(0), 64'h300);
    chk("wd_after_ack", 64'(fetch_timeout), 64'(WD));
    @(posedge CLK);
    #1 resetl = 1'b0;
    #1;
    chk("wd_cleared_by_reset", 64'(fetch_timeout), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
